// File: rtl/kmeans_k2n5_ctrl.sv
// Iteration sequencer for the k=2, 5-dimension k-means datapath: clears the
// accumulators, streams sample addresses, drains the pipeline and runs the update.
module kmeans_k2n5_ctrl #(
  parameter int input_data_qty_bit_width = 8,
  parameter int input_data_qty           = 256,
  parameter int pipe_latency             = 6,
  parameter int max_iterations           = 16,
  parameter int iter_width               = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                mem_rd_en,
  output logic [input_data_qty_bit_width-1:0] mem_rd_addr,
  output logic                                acc_clear,
  output logic                                acc_en,
  output logic                                upd_start,
  input  logic                                upd_done,
  input  logic                                centroid_changed,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic [iter_width-1:0]               iteration
);

  localparam int AW = input_data_qty_bit_width;
  localparam int CW = ($clog2(pipe_latency) > 0) ? $clog2(pipe_latency) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(input_data_qty - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(pipe_latency - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_CHECK  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]              state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [iter_width-1:0]   iter_q, iter_d;
  logic                    conv_q, conv_d;
  logic                    chg_q, chg_d;
  logic [pipe_latency-1:0] acc_pipe_q;

  // Iteration count sticks at all-ones rather than wrapping.
  function automatic logic [iter_width-1:0] sat_inc(input logic [iter_width-1:0] v);
    return (&v) ? v : v + iter_width'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    chg_d   = chg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        addr_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_LAST) state_d = S_UPDATE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_UPDATE: state_d = S_WAIT;
      S_WAIT: begin
        if (upd_done) begin
          chg_d   = centroid_changed;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        iter_d = sat_inc(iter_q);
        if (!chg_q) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if (int'(iter_q) + 1 == max_iterations) begin
          state_d = S_DONE;
          conv_d  = 1'b0;
        end else begin
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      chg_q   <= chg_d;
    end
  end

  // acc_en is the read strobe delayed to the accumulator inputs, independent of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_pipe_q <= '0;
    end else begin
      acc_pipe_q[0] <= mem_rd_en;
      for (int i = 1; i < pipe_latency; i++) acc_pipe_q[i] <= acc_pipe_q[i-1];
    end
  end

  assign mem_rd_en   = (state_q == S_STREAM);
  assign mem_rd_addr = addr_q;
  assign acc_clear   = (state_q == S_CLEAR);
  assign acc_en      = acc_pipe_q[pipe_latency-1];
  assign upd_start   = (state_q == S_UPDATE);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign converged   = conv_q;
  assign iteration   = iter_q;

endmodule

// File: tb/tb_kmeans_k2n5_ctrl.sv
// Scoreboard bench for kmeans_k2n5_ctrl: a driver pushes expected addresses and
// run outcomes, a negedge monitor pops and compares as the DUT produces them.
module tb_kmeans_k2n5_ctrl;
  localparam int N    = 8;
  localparam int L    = 3;
  localparam int MAXI = 4;
  localparam int AW   = 8;
  localparam int IW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          acc_clear;
  logic          acc_en;
  logic          upd_start;
  logic          upd_done;
  logic          centroid_changed;
  logic          busy;
  logic          done;
  logic          converged;
  logic [IW-1:0] iteration;

  kmeans_k2n5_ctrl #(
    .input_data_qty_bit_width(AW),
    .input_data_qty(N),
    .pipe_latency(L),
    .max_iterations(MAXI),
    .iter_width(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .acc_clear(acc_clear), .acc_en(acc_en), .upd_start(upd_start),
    .upd_done(upd_done), .centroid_changed(centroid_changed),
    .busy(busy), .done(done), .converged(converged), .iteration(iteration)
  );

  always #5 clk = ~clk;

  typedef struct {int iters; bit conv;} run_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_addr[$];
  int   rd_times[$];
  run_t exp_run[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference outcome: stop at the first unchanged update, else at the cap.
  task automatic model(input bit [MAXI-1:0] chg, output int iters, output bit conv);
    iters = MAXI;
    conv  = 1'b0;
    for (int k = 0; k < MAXI; k++) begin
      if (!chg[k]) begin
        iters = k + 1;
        conv  = 1'b1;
        break;
      end
    end
  endtask

  // Monitor
  int clr_t, updd_t, n_clr, n_upd, n_acc;
  bit pend, have_updd, wait_viol, done_prev;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_addr.delete(); rd_times.delete(); exp_run.delete();
        n_clr = 0; n_upd = 0; n_acc = 0;
        pend = 0; have_updd = 0; done_prev = 0;
      end else begin
        if (acc_clear) begin
          chk("clear_vs_acc_en", acc_en, 0);
          chk("iter_at_clear", iteration, n_clr);
          chk("conv_while_busy", converged, 0);
          if (have_updd) chk("clear_after_upd_done", cyc - updd_t, 2);
          n_clr++;
          clr_t = cyc;
        end
        if (mem_rd_en) begin
          chk("rd_expected", exp_addr.size() > 0, 1);
          if (exp_addr.size() > 0) chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
          if (mem_rd_addr == 0) chk("rd_first_lat", cyc - clr_t, 1);
          rd_times.push_back(cyc);
        end
        if (acc_en) begin
          n_acc++;
          chk("acc_has_read", rd_times.size() > 0, 1);
          if (rd_times.size() > 0) chk("acc_lat", cyc - rd_times.pop_front(), L);
        end
        if (upd_start) begin
          n_upd++;
          chk("upd_start_lat", cyc - clr_t, N + L + 1);
          pend = 1; wait_viol = 0;
        end else if (pend) begin
          if (mem_rd_en || acc_en || acc_clear) wait_viol = 1;
          if (upd_done) begin
            chk("wait_quiet", wait_viol, 0);
            pend = 0; have_updd = 1; updd_t = cyc;
          end
        end
        if (done && !done_prev) begin
          chk("run_expected", exp_run.size() > 0, 1);
          if (exp_run.size() > 0) begin
            run_t r;
            r = exp_run.pop_front();
            chk("iteration", iteration, r.iters);
            chk("converged", converged, r.conv);
            chk("acc_clear_count", n_clr, r.iters);
            chk("upd_start_count", n_upd, r.iters);
            chk("acc_en_count", n_acc, r.iters * N);
          end
          chk("addr_left", exp_addr.size(), 0);
          chk("done_lat", cyc - updd_t, 2);
          chk("busy_in_done", busy, 0);
          n_clr = 0; n_upd = 0; n_acc = 0; have_updd = 0;
        end
        done_prev = done;
      end
    end
  end

  task automatic push_run(input bit [MAXI-1:0] chg);
    int  it;
    bit  cv;
    run_t r;
    model(chg, it, cv);
    r.iters = it; r.conv = cv;
    exp_run.push_back(r);
    for (int i = 0; i < it; i++)
      for (int a = 0; a < N; a++) exp_addr.push_back(a);
  endtask

  // dly=0 picks a random update latency per iteration.
  task automatic do_run(input bit [MAXI-1:0] chg, input int dly, input bit hold, input bit stray);
    int it, k, d;
    bit cv;
    model(chg, it, cv);
    push_run(chg);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 if (!hold) start = 1'b0;
    if (stray) begin
      repeat (3) @(posedge clk);
      #1 upd_done = 1'b1; centroid_changed = 1'b0;
      @(posedge clk); #1 upd_done = 1'b0;
    end
    k = 0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      if (done) break;
      centroid_changed = 1'($urandom_range(0, 1));
      if (upd_start) begin
        if (k == it - 1) start = 1'b0;
        d = (dly > 0) ? dly : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1 upd_done = 1'b1; centroid_changed = chg[k];
        @(posedge clk); #1 upd_done = 1'b0;
        k++;
      end
    end
    start = 1'b0;
    chk("run_done", done, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cnt;
    rst = 1'b0; start = 1'b0; upd_done = 1'b0; centroid_changed = 1'b0;
    #3;
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_upd_start", upd_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_converged", converged, 0);
    chk("rst_iteration", iteration, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    do_run(4'b0000, 2, 1'b0, 1'b0);
    do_run(4'b1111, 0, 1'b0, 1'b0);
    do_run(4'b1011, 0, 1'b0, 1'b0);
    do_run(4'b0111, 0, 1'b1, 1'b1);
    do_run(4'b0101, 50, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++)
      do_run(MAXI'($urandom), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Abort mid-stream at address 5.
    push_run(4'b0000);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (mem_rd_en && mem_rd_addr == 5) found = 1;
    end
    chk("reach_addr5", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_rd_en", mem_rd_en, 0);
    chk("abort_addr", mem_rd_addr, 0);
    chk("abort_acc_en", acc_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_iteration", iteration, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (acc_en || mem_rd_en || upd_start) cnt++;
    end
    chk("post_abort_strobes", cnt, 0);
    chk("post_abort_idle", busy | done, 0);

    do_run(4'b1101, 0, 1'b0, 1'b0);
    do_run(4'b0011, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kmeans_k2n5_ctrl.md
Name: kmeans_k2n5_ctrl

Overview:
- Iteration sequencer for the k=2, 5-dimension k-means datapath.
- Per iteration:
  - clears the centroid accumulators;
  - streams every sample address to the five dimension memories;
  - tracks in-flight samples through the fixed-latency distance/classify pipeline;
  - triggers the centroid update unit and decides whether to iterate again or finish.
- Sits between the top-level start input and the memories, accumulators and update unit.

Parameters:
- input_data_qty_bit_width, 8, width of sample address.
- input_data_qty, 256, samples per iteration (1..2^input_data_qty_bit_width).
- pipe_latency, 6, cycles from mem_rd_en to the matching sample at the accumulator inputs (>=1).
- max_iterations, 16, iteration cap (>=1).
- iter_width, 8, width of the iteration counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level; launches a run from IDLE or DONE.
- mem_rd_en  out  1  read strobe to the five data memories.
- mem_rd_addr  out  input_data_qty_bit_width  sample address.
- acc_clear  out  1  one-cycle accumulator/counter clear.
- acc_en  out  1  accumulate strobe, aligned to pipeline output.
- upd_start  out  1  one-cycle pulse to the centroid update unit.
- upd_done  in  1  one-cycle pulse; new centroids written.
- centroid_changed  in  1  valid with upd_done; any centroid moved.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.
- converged  out  1  valid in DONE; 1 = stopped because no change.
- iteration  out  iter_width  completed iterations of the current run.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE;
  - all outputs 0; mem_rd_addr=0; iteration=0; converged=0;
  - acc_en delay line cleared.
  - Reset mid-run aborts immediately; no upd_start is issued afterwards.
- IDLE: start=1 -> CLEAR, iteration<=0.
- CLEAR: acc_clear=1 for exactly this cycle; mem_rd_addr<=0; -> STREAM.
- STREAM:
  - mem_rd_en=1 every cycle; mem_rd_addr increments each cycle.
  - When mem_rd_addr==input_data_qty-1 this cycle -> DRAIN, addr holds.
  - Exactly input_data_qty consecutive strobes, addresses 0..N-1, no gaps.
- acc_en:
  - mem_rd_en delayed by pipe_latency cycles through a shift register.
  - Runs independently of state, so it yields exactly N pulses per iteration.
- DRAIN:
  - mem_rd_en=0; counter runs pipe_latency cycles; then -> UPDATE.
  - The last acc_en pulse occurs in the final DRAIN cycle.
- UPDATE: upd_start=1 for one cycle; -> WAIT_UPD.
- WAIT_UPD:
  - Waits indefinitely for upd_done.
  - On upd_done, capture centroid_changed into chg_r; -> CHECK.
  - upd_done in any other state is ignored.
- CHECK (one cycle): iteration<=iteration+1, then:
  - if chg_r=0 -> DONE, converged<=1;
  - else if iteration+1==max_iterations -> DONE, converged<=0;
  - else -> CLEAR.
  - iteration saturates at all-ones if iter_width is too small.
- DONE: done=1, busy=0; outputs held. start=1 -> CLEAR with iteration<=0, converged<=0.
- start is ignored while busy=1.
- Iteration length = 1 + N + pipe_latency + 1 + T_upd + 1 cycles, where T_upd is the number of WAIT_UPD cycles.
- acc_clear and acc_en are never high in the same cycle; acc_clear never coincides with in-flight samples.

Test Plan (all with input_data_qty=8, pipe_latency=3, max_iterations=4):
- Single iteration, convergence: start pulse; upd_done 2 cycles after upd_start with centroid_changed=0 ->
  - acc_clear one cycle; mem_rd_en 8 cycles, addr 0..7;
  - acc_en 8 pulses starting 3 cycles after the first mem_rd_en;
  - done=1, converged=1, iteration=1.
- Iteration cap: centroid_changed=1 always -> 4 acc_clear pulses and 4 upd_start pulses; done with iteration=4, converged=0.
- Convergence on third iteration: changed=1,1,0 -> iteration=3, converged=1; exactly 24 acc_en pulses total.
- Stray and busy inputs:
  - start held high during the run: no restart.
  - upd_done pulsed during STREAM: ignored, no extra upd_start.
  - Delayed upd_done (50 cycles): FSM waits with all strobes low.
- Reset mid-STREAM at addr=5: outputs 0 asynchronously; after release, IDLE with no acc_en pulses from the aborted samples.
- Restart from DONE: start=1 -> new run, iteration restarts at 0, converged cleared, addresses restart at 0.
